// File: rtl/alarm_pkg.sv
// ----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the multi-channel alarm controller:
//   - alarm_state_e : per-channel state encoding (2 bits)
//   - BTN_*         : bit positions of the buttons in the edge-detect vector
//   - bcd_min_inc   : BCD minute increment, 59 wraps to 00
//   - bcd_hour_inc  : BCD hour increment, 23 wraps to 00
//   - cnt_w         : bits needed to hold a counter value 0..max_val
// No ports (package).
// ----------------------------------------------------------------------------
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZED = 2'd2
   } alarm_state_e;

   localparam int BTN_MIN    = 0;
   localparam int BTN_HOUR   = 1;
   localparam int BTN_TOGGLE = 2;
   localparam int BTN_CLEAR  = 3;
   localparam int BTN_STOP   = 4;
   localparam int BTN_SNOOZE = 5;
   localparam int BTN_N      = 6;

   // v is {ten, one}; no carry into the hour.
   function automatic logic [7:0] bcd_min_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h59)
         r = 8'h00;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // v is {ten, one}, 24 h format.
   function automatic logic [7:0] bcd_hour_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h23)
         r = 8'h00;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic int cnt_w(input int max_val);
      int w;
      w = 1;
      while ((1 << w) <= max_val)
         w++;
      return w;
   endfunction

endpackage

// File: rtl/multi_alarm_ctrl_if.sv
// ----------------------------------------------------------------------------
// multi_alarm_ctrl_if
// Bundles everything the alarm controller exchanges with the clock top level
// apart from clk/rst.
//   Inputs to the controller : tick_1hz, cur_* (BCD time), enable_set, sel,
//                              btn_min/hour/toggle/clear/stop/snooze
//   Outputs of the controller: al_* (selected channel time), sel_enabled,
//                              enabled_mask, ringing_mask, alarm_trigger,
//                              active_idx, piezo_out, blink
// Modports: master drives the inputs, slave is the controller.
// ----------------------------------------------------------------------------
interface multi_alarm_ctrl_if #(
   parameter int NUM_ALARMS = 4,
   parameter int SEL_W      = 3
);
   logic                  tick_1hz;
   logic [3:0]            cur_h_ten, cur_h_one;
   logic [3:0]            cur_m_ten, cur_m_one;
   logic [3:0]            cur_s_ten, cur_s_one;
   logic                  enable_set;
   logic [SEL_W-1:0]      sel;
   logic                  btn_min, btn_hour, btn_toggle, btn_clear;
   logic                  btn_stop, btn_snooze;

   logic [3:0]            al_h_ten, al_h_one, al_m_ten, al_m_one;
   logic                  sel_enabled;
   logic [NUM_ALARMS-1:0] enabled_mask;
   logic [NUM_ALARMS-1:0] ringing_mask;
   logic                  alarm_trigger;
   logic [SEL_W-1:0]      active_idx;
   logic                  piezo_out;
   logic                  blink;

   modport master (
      output tick_1hz, cur_h_ten, cur_h_one, cur_m_ten, cur_m_one,
             cur_s_ten, cur_s_one, enable_set, sel,
             btn_min, btn_hour, btn_toggle, btn_clear, btn_stop, btn_snooze,
      input  al_h_ten, al_h_one, al_m_ten, al_m_one, sel_enabled,
             enabled_mask, ringing_mask, alarm_trigger, active_idx,
             piezo_out, blink
   );

   modport slave (
      input  tick_1hz, cur_h_ten, cur_h_one, cur_m_ten, cur_m_one,
             cur_s_ten, cur_s_one, enable_set, sel,
             btn_min, btn_hour, btn_toggle, btn_clear, btn_stop, btn_snooze,
      output al_h_ten, al_h_one, al_m_ten, al_m_one, sel_enabled,
             enabled_mask, ringing_mask, alarm_trigger, active_idx,
             piezo_out, blink
   );
endinterface

// File: rtl/alarm_channel.sv
// ----------------------------------------------------------------------------
// alarm_channel
// One alarm channel: stored BCD alarm time and enable bit, match edge
// detection against the current time, and the IDLE/RINGING/SNOOZED state
// machine with its seconds and snooze counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   tick_1hz                 one-cycle 1 Hz pulse
//   enable_set               set mode active (suppresses new triggers)
//   cur_h, cur_m, cur_s      current time, BCD {ten,one}
//   ed_min/hour/toggle/clear edit strobes, already qualified for this channel
//   stop_req, snooze_req     broadcast stop/snooze strobes
//   al_h, al_m               stored alarm time, BCD {ten,one}
//   enabled, ringing         enable bit, RINGING flag
// ----------------------------------------------------------------------------
module alarm_channel
   import alarm_pkg::*;
#(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       enable_set,
   input  logic [7:0] cur_h,
   input  logic [7:0] cur_m,
   input  logic [7:0] cur_s,
   input  logic       ed_min,
   input  logic       ed_hour,
   input  logic       ed_toggle,
   input  logic       ed_clear,
   input  logic       stop_req,
   input  logic       snooze_req,
   output logic [7:0] al_h,
   output logic [7:0] al_m,
   output logic       enabled,
   output logic       ringing
);

   localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
   localparam int SEC_W   = cnt_w(SEC_MAX);
   localparam int SNZ_W   = cnt_w(MAX_SNOOZE);

   alarm_state_e     state_p0, state_nxt;
   logic [SEC_W-1:0] sec_p0,   sec_nxt;
   logic [SNZ_W-1:0] snz_p0,   snz_nxt;
   logic [7:0]       h_p0,     h_nxt;
   logic [7:0]       m_p0,     m_nxt;
   logic             en_p0,    en_nxt;
   logic             match_p0;
   logic             match;
   logic             trig;

   // Register stage: all channel state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0 <= IDLE;
         sec_p0   <= '0;
         snz_p0   <= '0;
         h_p0     <= 8'h00;
         m_p0     <= 8'h00;
         en_p0    <= 1'b0;
         match_p0 <= 1'b0;
      end else begin
         state_p0 <= state_nxt;
         sec_p0   <= sec_nxt;
         snz_p0   <= snz_nxt;
         h_p0     <= h_nxt;
         m_p0     <= m_nxt;
         en_p0    <= en_nxt;
         match_p0 <= match;
      end
   end

   always_comb begin
      match     = en_p0 && (cur_h == h_p0) && (cur_m == m_p0) && (cur_s == 8'h00);
      // Rising edge of match so a held minute fires only once.
      trig      = match && !match_p0 && !enable_set;

      state_nxt = state_p0;
      sec_nxt   = sec_p0;
      snz_nxt   = snz_p0;
      h_nxt     = h_p0;
      m_nxt     = m_p0;
      en_nxt    = en_p0;

      if (ed_min)
         m_nxt = bcd_min_inc(m_p0);
      if (ed_hour)
         h_nxt = bcd_hour_inc(h_p0);

      // Edits on this channel take precedence over any FSM event.
      if (ed_clear) begin
         h_nxt     = 8'h00;
         m_nxt     = 8'h00;
         en_nxt    = 1'b0;
         state_nxt = IDLE;
         sec_nxt   = '0;
         snz_nxt   = '0;
      end else if (ed_toggle) begin
         en_nxt = !en_p0;
         if (en_p0)
            state_nxt = IDLE;
      end else begin
         case (state_p0)
            IDLE: begin
               if (trig) begin
                  state_nxt = RINGING;
                  sec_nxt   = '0;
                  snz_nxt   = '0;
               end
            end
            RINGING: begin
               if (stop_req) begin
                  state_nxt = IDLE;
               end else if (snooze_req) begin
                  if (snz_p0 < SNZ_W'(MAX_SNOOZE)) begin
                     state_nxt = SNOOZED;
                     snz_nxt   = snz_p0 + 1'b1;
                     sec_nxt   = '0;
                  end else begin
                     // Snooze budget used up: this press acts as stop.
                     state_nxt = IDLE;
                  end
               end else if (tick_1hz) begin
                  if (sec_p0 == SEC_W'(RING_SEC - 1)) begin
                     state_nxt = IDLE;
                     sec_nxt   = '0;
                  end else begin
                     sec_nxt = sec_p0 + 1'b1;
                  end
               end
            end
            SNOOZED: begin
               if (stop_req) begin
                  state_nxt = IDLE;
               end else if (trig) begin
                  state_nxt = RINGING;
                  sec_nxt   = '0;
                  snz_nxt   = '0;
               end else if (tick_1hz) begin
                  if (sec_p0 == SEC_W'(SNOOZE_SEC - 1)) begin
                     state_nxt = RINGING;
                     sec_nxt   = '0;
                  end else begin
                     sec_nxt = sec_p0 + 1'b1;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign al_h    = h_p0;
   assign al_m    = m_p0;
   assign enabled = en_p0;
   assign ringing = (state_p0 == RINGING);

endmodule

// File: rtl/multi_alarm_ctrl.sv
// ----------------------------------------------------------------------------
// multi_alarm_ctrl
// NUM_ALARMS independent hour:minute alarms beside time_counter. Performs
// button edge detection, selects the channel being edited/displayed, and
// produces the combined ringing status, piezo tone and blink.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       multi_alarm_ctrl_if.slave: tick_1hz, BCD current time,
//             enable_set, sel, buttons in; al_*, sel_enabled, enabled_mask,
//             ringing_mask, alarm_trigger, active_idx, piezo_out, blink out
// ----------------------------------------------------------------------------
module multi_alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_SEC = 300,
   parameter int MAX_SNOOZE = 3,
   parameter int TONE_DIV   = 1,
   parameter int SEL_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   multi_alarm_ctrl_if.slave bus
);

   localparam int TDIV_W = cnt_w(TONE_DIV);

   logic [BTN_N-1:0]      btn_now, btn_lvl_p0, btn_edge_p1;
   logic                  sel_valid, set_ok;
   logic [7:0]            cur_h, cur_m, cur_s;
   logic [7:0]            ch_al_h [NUM_ALARMS];
   logic [7:0]            ch_al_m [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] en_mask, ring_mask;
   logic                  any_ring;
   logic [SEL_W-1:0]      idx;
   logic [7:0]            disp_h, disp_m;
   logic                  disp_en;
   logic [TDIV_W-1:0]     tone_div_p0;
   logic                  tone_p0, blink_p0;

   assign btn_now = {bus.btn_snooze, bus.btn_stop, bus.btn_clear,
                     bus.btn_toggle, bus.btn_hour, bus.btn_min};

   // Stage p0: previous button levels; stage p1: registered rising edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_lvl_p0  <= '0;
         btn_edge_p1 <= '0;
      end else begin
         btn_lvl_p0  <= btn_now;
         btn_edge_p1 <= btn_now & ~btn_lvl_p0;
      end
   end

   assign cur_h     = {bus.cur_h_ten, bus.cur_h_one};
   assign cur_m     = {bus.cur_m_ten, bus.cur_m_one};
   assign cur_s     = {bus.cur_s_ten, bus.cur_s_one};
   assign sel_valid = int'(bus.sel) < NUM_ALARMS;
   assign set_ok    = bus.enable_set && sel_valid;

   for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
      logic hit;
      assign hit = set_ok && (bus.sel == SEL_W'(i));

      alarm_channel #(
         .RING_SEC  (RING_SEC),
         .SNOOZE_SEC(SNOOZE_SEC),
         .MAX_SNOOZE(MAX_SNOOZE)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .tick_1hz  (bus.tick_1hz),
         .enable_set(bus.enable_set),
         .cur_h     (cur_h),
         .cur_m     (cur_m),
         .cur_s     (cur_s),
         .ed_min    (hit && btn_edge_p1[BTN_MIN]),
         .ed_hour   (hit && btn_edge_p1[BTN_HOUR]),
         .ed_toggle (hit && btn_edge_p1[BTN_TOGGLE]),
         .ed_clear  (hit && btn_edge_p1[BTN_CLEAR]),
         .stop_req  (btn_edge_p1[BTN_STOP]),
         .snooze_req(btn_edge_p1[BTN_SNOOZE]),
         .al_h      (ch_al_h[i]),
         .al_m      (ch_al_m[i]),
         .enabled   (en_mask[i]),
         .ringing   (ring_mask[i])
      );
   end

   // Display mux for the selected channel; out-of-range sel reads zero.
   always_comb begin
      disp_h  = 8'h00;
      disp_m  = 8'h00;
      disp_en = 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (sel_valid && (bus.sel == SEL_W'(i))) begin
            disp_h  = ch_al_h[i];
            disp_m  = ch_al_m[i];
            disp_en = en_mask[i];
         end
      end
   end

   // Lowest-index ringing channel wins; scan downwards so it is written last.
   always_comb begin
      idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (ring_mask[i])
            idx = SEL_W'(i);
      end
   end

   assign any_ring = |ring_mask;

   // Tone and blink registers, held at zero whenever nothing rings.
   always_ff @(posedge clk) begin
      if (rst || !any_ring) begin
         tone_div_p0 <= '0;
         tone_p0     <= 1'b0;
         blink_p0    <= 1'b0;
      end else begin
         if (tone_div_p0 == TDIV_W'(TONE_DIV - 1)) begin
            tone_div_p0 <= '0;
            tone_p0     <= ~tone_p0;
         end else begin
            tone_div_p0 <= tone_div_p0 + 1'b1;
         end
         if (bus.tick_1hz)
            blink_p0 <= ~blink_p0;
      end
   end

   assign bus.al_h_ten      = disp_h[7:4];
   assign bus.al_h_one      = disp_h[3:0];
   assign bus.al_m_ten      = disp_m[7:4];
   assign bus.al_m_one      = disp_m[3:0];
   assign bus.sel_enabled   = disp_en;
   assign bus.enabled_mask  = en_mask;
   assign bus.ringing_mask  = ring_mask;
   assign bus.alarm_trigger = any_ring;
   assign bus.active_idx    = idx;
   assign bus.piezo_out     = tone_p0 && any_ring;
   assign bus.blink         = blink_p0 && any_ring;

endmodule
